coffee_brew_sequencer: RTL
==========================

# coffee_brew_sequencer

Recipe sequencer for the coffee machine. Accepts a drink request (espresso, leche, capuchino, optional sugar), steps through the brewing phases with per-phase cycle timers, drives one actuator enable per phase, and supplies the two 4-bit character codes consumed by the seven-segment display decoders: one for drink type, one for current phase.

## Interface
Parameters:
- T_WATER, 8, cycles in AGUA phase (≥1)
- T_COFFEE, 6, cycles in CAFE phase (≥1)
- T_MILK, 5, cycles in LECHE phase (≥1)
- T_SUGAR, 3, cycles in AZUCAR phase (≥1)
- T_FOAM, 4, cycles in CREMA phase (≥1)
- T_FIN, 2, cycles in FIN phase (≥1)
- CNT_W, 16, phase counter width; every T_* ≤ 2^CNT_W

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request pulse/level, sampled only in IDLE
- coffee_sel  in  2  0 espresso, 1 leche, 2 capuchino, 3 invalid
- sugar  in  1  add AZUCAR phase
- cancel  in  1  abort request (see Configuration)
- type_char  out  4  drink code: 0 E, 1 L, 2 C; 15 blank
- state_char  out  4  phase code: 3 A, 4 C, 5 L, 6 U, 7 E, 8 F; 15 blank
- water_on, coffee_on, milk_on, sugar_on, foam_on  out  1 each  actuator enables
- busy  out  1  high in any non-IDLE state
- done  out  1  high throughout FIN

## Operation
- States: IDLE, AGUA, CAFE, LECHE, AZUCAR, CREMA, FIN.
- IDLE: start=1 and coffee_sel≤2 → latch coffee_sel and sugar, go to AGUA. coffee_sel=3 → start ignored, remain IDLE.
- Phase order: AGUA → CAFE → [LECHE if leche/capuchino] → [AZUCAR if latched sugar] → [CREMA if capuchino] → FIN → IDLE.
- Each phase lasts exactly its T_* cycles: counter loaded with T−1 on entry, decrements, phase exits when counter=0.
- Actuators one-hot by phase: AGUA water_on, CAFE coffee_on, LECHE milk_on, AZUCAR sugar_on, CREMA foam_on. FIN and IDLE: all off.
- type_char = latched drink code while busy, 15 in IDLE. state_char = code of current phase, 15 in IDLE.
- start, coffee_sel, sugar ignored while busy; latched values are stable for the whole brew.
- All outputs registered; they change in the same cycle as the state register.

## Timing
- Reset (rst_n=0 at an edge, any state, including mid-brew): state IDLE, counter 0, type_char=15, state_char=15, all actuators 0, busy=0, done=0. Next edge with rst_n=1 and start=1 may begin a brew.
- Start accepted at edge N → outputs show AGUA from cycle N+1.
- Total busy length = sum of T_* of phases taken (FIN included); busy falls the cycle after last FIN cycle.
- Back-to-back: start held high through FIN→IDLE begins a new brew one cycle after IDLE is entered (one IDLE cycle minimum between brews).
- Phase transitions are gapless: last cycle of one phase immediately followed by first cycle of the next.

## Configuration
- CANCEL_EN defined: cancel=1 sampled in AGUA, CAFE, LECHE, AZUCAR or CREMA → next cycle enters FIN (full T_FIN, all actuators off, done=1), then IDLE. cancel in FIN or IDLE has no effect; cancel and start together in IDLE → start accepted.
- CANCEL_EN undefined: cancel port present but ignored; every accepted brew runs to completion.

## Test plan
- Espresso, no sugar, start at cycle 0 → AGUA cycles 1–8 (state_char 3, water_on), CAFE 9–14 (4), FIN 15–16 (8, done), IDLE at 17, type_char 0 for cycles 1–16.
- Capuchino with sugar, default params → phases A,C,L,U,E,F lasting 8,6,5,3,4,2; busy cycles 1–28; type_char 2; exactly one actuator high per brewing cycle.
- coffee_sel=3 with start → stays IDLE, busy=0, outputs 15/15; start during busy with different coffee_sel → latched type unchanged.
- rst_n=0 during LECHE → next cycle all outputs at reset values; new leche start after release brews fully.
- CANCEL_EN: cancel in CAFE cycle 10 → FIN at cycles 11–12, coffee_on low from 11, IDLE at 13; without macro same stimulus → normal completion.
- Start held high continuously, espresso → busy 1–16, IDLE at 17, second brew AGUA from 18.

Source files
------------

// File: rtl/coffee_brew_sequencer_if.sv
// ----------------------------------------------------------------------------
// coffee_brew_sequencer_if : request inputs and display/actuator outputs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface coffee_brew_sequencer_if;
  logic       start;
  logic [1:0] coffee_sel;
  logic       sugar;
  logic       cancel;
  logic [3:0] type_char;
  logic [3:0] state_char;
  logic       water_on;
  logic       coffee_on;
  logic       milk_on;
  logic       sugar_on;
  logic       foam_on;
  logic       busy;
  logic       done;

  modport slave (
    input  start, coffee_sel, sugar, cancel,
    output type_char, state_char, water_on, coffee_on, milk_on,
           sugar_on, foam_on, busy, done
  );

  modport master (
    output start, coffee_sel, sugar, cancel,
    input  type_char, state_char, water_on, coffee_on, milk_on,
           sugar_on, foam_on, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/coffee_brew_sequencer.sv
// ----------------------------------------------------------------------------
// coffee_brew_sequencer : timed recipe phase sequencer; CANCEL_EN enables abort
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module coffee_brew_sequencer #(
  parameter int T_WATER  = 8,
  parameter int T_COFFEE = 6,
  parameter int T_MILK   = 5,
  parameter int T_SUGAR  = 3,
  parameter int T_FOAM   = 4,
  parameter int T_FIN    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  coffee_brew_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AGUA   = 3'd1,
    ST_CAFE   = 3'd2,
    ST_LECHE  = 3'd3,
    ST_AZUCAR = 3'd4,
    ST_CREMA  = 3'd5,
    ST_FIN    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] C_LD_WATER  = CNT_W'(T_WATER - 1);
  localparam logic [CNT_W-1:0] C_LD_COFFEE = CNT_W'(T_COFFEE - 1);
  localparam logic [CNT_W-1:0] C_LD_MILK   = CNT_W'(T_MILK - 1);
  localparam logic [CNT_W-1:0] C_LD_SUGAR  = CNT_W'(T_SUGAR - 1);
  localparam logic [CNT_W-1:0] C_LD_FOAM   = CNT_W'(T_FOAM - 1);
  localparam logic [CNT_W-1:0] C_LD_FIN    = CNT_W'(T_FIN - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic             r_sugar, w_sugar_nxt;
  logic             w_abort;

  logic [3:0]       r_type_char, w_type_char;
  logic [3:0]       r_state_char, w_state_char;
  logic [4:0]       r_act, w_act;
  logic             r_busy, w_busy;
  logic             r_done, w_done;

`ifdef CANCEL_EN
  assign w_abort = bus.cancel;
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
  assign w_abort       = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] load_for(input state_t s);
    case (s)
      ST_AGUA:   load_for = C_LD_WATER;
      ST_CAFE:   load_for = C_LD_COFFEE;
      ST_LECHE:  load_for = C_LD_MILK;
      ST_AZUCAR: load_for = C_LD_SUGAR;
      ST_CREMA:  load_for = C_LD_FOAM;
      ST_FIN:    load_for = C_LD_FIN;
      default:   load_for = '0;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_sugar_nxt = r_sugar;

    case (r_state)
      ST_IDLE: begin
        if (bus.start && (bus.coffee_sel != 2'd3)) begin
          w_state_nxt = ST_AGUA;
          w_sel_nxt   = bus.coffee_sel;
          w_sugar_nxt = bus.sugar;
        end
      end
      ST_FIN: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
      end
      default: begin
        if (w_abort) begin
          w_state_nxt = ST_FIN;
        end else if (r_cnt == '0) begin
          // Optional phases are skipped by falling through to the next one that applies.
          case (r_state)
            ST_AGUA:   w_state_nxt = ST_CAFE;
            ST_CAFE:   w_state_nxt = (r_sel != 2'd0) ? ST_LECHE :
                                     r_sugar         ? ST_AZUCAR :
                                     (r_sel == 2'd2) ? ST_CREMA : ST_FIN;
            ST_LECHE:  w_state_nxt = r_sugar         ? ST_AZUCAR :
                                     (r_sel == 2'd2) ? ST_CREMA : ST_FIN;
            ST_AZUCAR: w_state_nxt = (r_sel == 2'd2) ? ST_CREMA : ST_FIN;
            default:   w_state_nxt = ST_FIN;
          endcase
        end
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = load_for(w_state_nxt);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    // Outputs are decoded from the next state so they register alongside it.
    w_busy       = (w_state_nxt != ST_IDLE);
    w_done       = (w_state_nxt == ST_FIN);
    w_type_char  = w_busy ? {2'b00, w_sel_nxt} : 4'd15;
    w_state_char = 4'd15;
    w_act        = 5'b00000;
    case (w_state_nxt)
      ST_AGUA:   begin w_state_char = 4'd3; w_act = 5'b00001; end
      ST_CAFE:   begin w_state_char = 4'd4; w_act = 5'b00010; end
      ST_LECHE:  begin w_state_char = 4'd5; w_act = 5'b00100; end
      ST_AZUCAR: begin w_state_char = 4'd6; w_act = 5'b01000; end
      ST_CREMA:  begin w_state_char = 4'd7; w_act = 5'b10000; end
      ST_FIN:    begin w_state_char = 4'd8; end
      default:   begin w_state_char = 4'd15; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      r_sugar      <= 1'b0;
      r_type_char  <= 4'd15;
      r_state_char <= 4'd15;
      r_act        <= 5'b00000;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_sugar      <= w_sugar_nxt;
      r_type_char  <= w_type_char;
      r_state_char <= w_state_char;
      r_act        <= w_act;
      r_busy       <= w_busy;
      r_done       <= w_done;
    end
  end

  assign bus.type_char  = r_type_char;
  assign bus.state_char = r_state_char;
  assign bus.water_on   = r_act[0];
  assign bus.coffee_on  = r_act[1];
  assign bus.milk_on    = r_act[2];
  assign bus.sugar_on   = r_act[3];
  assign bus.foam_on    = r_act[4];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

`default_nettype wire
